// File: rtl/seq_shifter_if.sv
// Request/result bundle for the iterative shift unit.
// The master side issues operands and start; the slave side returns the result and status.
interface seq_shifter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             dir;
  logic             arith;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;

  modport master (
    output start, dir, arith, shamt, din,
    input  dout, busy, done
  );

  modport slave (
    input  start, dir, arith, shamt, din,
    output dout, busy, done
  );
endinterface

// File: rtl/seq_shifter.sv
// Iterative 32-bit SLL/SRL/SRA unit, one bit per clock under a start/done handshake.
// Optional macro SEQ_SHIFTER_FAST_EN: retire two bits per clock while at least two remain.
module seq_shifter #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_shifter_if.slave  bus
);

  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               accept_s;
  logic               busy_nxt_s;
  logic               done_nxt_s;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   data_r;
  logic [WIDTH-1:0]   dout_r;
  logic [SHAMT_W-1:0] count_r;
  logic               dir_r;
  logic               arith_r;
  logic [WIDTH-1:0]   step_data_s;
  logic [SHAMT_W-1:0] step_count_s;

  // Right shifts fill with the current MSB only when arithmetic; that MSB is still the original sign.
  function automatic logic [WIDTH-1:0] shift_one(
    input logic [WIDTH-1:0] d,
    input logic             right,
    input logic             sign_fill
  );
    logic [WIDTH-1:0] r;
    if (right) begin
      r = {(sign_fill & d[WIDTH-1]), d[WIDTH-1:1]};
    end else begin
      r = {d[WIDTH-2:0], 1'b0};
    end
    return r;
  endfunction

  assign accept_s = bus.start & ((state_r == ST_IDLE) | (state_r == ST_DONE));

  // State register, with status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (count_r == 5'd0) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (accept_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Status decode of the upcoming state so busy/done leave flops directly.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
      ST_SHIFT: begin
        busy_nxt_s = 1'b1;
        done_nxt_s = 1'b0;
      end
      ST_DONE: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // One iteration step of the shift datapath.
  always_comb begin
    step_data_s  = shift_one(data_r, dir_r, arith_r);
    step_count_s = count_r - 5'd1;
`ifdef SEQ_SHIFTER_FAST_EN
    if (count_r >= 5'd2) begin
      step_data_s  = shift_one(shift_one(data_r, dir_r, arith_r), dir_r, arith_r);
      step_count_s = count_r - 5'd2;
    end else begin
      step_data_s  = shift_one(data_r, dir_r, arith_r);
      step_count_s = count_r - 5'd1;
    end
`endif
  end

  // Operand capture on accept, iteration in SHIFT, result publish when the count runs out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= {WIDTH{1'b0}};
      dout_r  <= {WIDTH{1'b0}};
      count_r <= 5'd0;
      dir_r   <= 1'b0;
      arith_r <= 1'b0;
    end else if (accept_s) begin
      data_r  <= bus.din;
      count_r <= bus.shamt;
      dir_r   <= bus.dir;
      arith_r <= bus.arith;
    end else if (state_r == ST_SHIFT) begin
      if (count_r != 5'd0) begin
        data_r  <= step_data_s;
        count_r <= step_count_s;
      end else begin
        dout_r  <= data_r;
      end
    end
  end

  assign bus.dout = dout_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule
